// File: rtl/str_route_if.sv
// Valid/ready stream bundle used for the DMA input and both coprocessor outputs.
interface str_route_if #(
    parameter int W = 64
) ();
    logic [W-1:0] bus;
    logic         val;
    logic         rdy;

    modport master (output bus, output val, input rdy);
    modport slave  (input bus, input val, output rdy);
endinterface

// File: rtl/str_route.sv
// Steers one DMA stream onto the kernel and image inputs by configured word counts.
// Each output carries one registered stage; the FSM selects which one is fed.
module str_route #(
    parameter int                    CFG_DWIDTH   = 32,
    parameter int                    CFG_AWIDTH   = 5,
    parameter int                    STR_WIDTH    = 64,
    parameter int                    CNT_WIDTH    = 24,
    parameter logic [CFG_AWIDTH-1:0] CFG_KER_ADDR = 5'd24,
    parameter logic [CFG_AWIDTH-1:0] CFG_IMG_ADDR = 5'd25
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CFG_DWIDTH-1:0] cfg_data,
    input  logic [CFG_AWIDTH-1:0] cfg_addr,
    input  logic                  cfg_valid,
    str_route_if.slave            up,
    str_route_if.master           ker,
    str_route_if.master           img,
    output logic                  ker_done,
    output logic                  img_done,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, KER, IMG} state_e;

    state_e                 state_q, state_d;
    logic                   ker_arm_q, ker_arm_d;
    logic                   img_arm_q, img_arm_d;
    logic [CNT_WIDTH-1:0]   ker_cnt_q, ker_cnt_d;
    logic [CNT_WIDTH-1:0]   img_cnt_q, img_cnt_d;
    logic [STR_WIDTH-1:0]   ker_bus_q, ker_bus_d;
    logic [STR_WIDTH-1:0]   img_bus_q, img_bus_d;
    logic                   ker_val_q, ker_val_d;
    logic                   img_val_q, img_val_d;
    logic                   ker_done_q, ker_done_d;
    logic                   img_done_q, img_done_d;

    logic [CNT_WIDTH-1:0]   cfg_cnt;
    logic                   unused_cfg;
    logic                   up_rdy;
    logic                   hs;
    logic                   ker_load, img_load;
    logic                   ker_wr, img_wr;
    logic                   ker_pend, img_pend;

    assign cfg_cnt    = cfg_data[CNT_WIDTH-1:0];
    assign unused_cfg = ^cfg_data[CFG_DWIDTH-1:CNT_WIDTH];

    assign up_rdy = (state_q == KER && (!ker_val_q || ker.rdy)) ||
                    (state_q == IMG && (!img_val_q || img.rdy));
    assign hs       = up.val && up_rdy;
    assign ker_load = hs && state_q == KER;
    assign img_load = hs && state_q == IMG;

    assign ker_wr = cfg_valid && cfg_addr == CFG_KER_ADDR &&
                    cfg_cnt != '0 && !ker_arm_q && state_q != KER;
    assign img_wr = cfg_valid && cfg_addr == CFG_IMG_ADDR &&
                    cfg_cnt != '0 && !img_arm_q && state_q != IMG;

    // A write landing this cycle is seen by the transition taken at the same edge
    assign ker_pend = ker_arm_q || ker_wr;
    assign img_pend = img_arm_q || img_wr;

    always_comb begin
        state_d    = state_q;
        ker_arm_d  = ker_arm_q;
        img_arm_d  = img_arm_q;
        ker_cnt_d  = ker_cnt_q;
        img_cnt_d  = img_cnt_q;
        ker_done_d = 1'b0;
        img_done_d = 1'b0;

        if (ker_wr) begin
            ker_cnt_d = cfg_cnt;
            ker_arm_d = 1'b1;
        end
        if (img_wr) begin
            img_cnt_d = cfg_cnt;
            img_arm_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (ker_pend) begin
                    state_d   = KER;
                    ker_arm_d = 1'b0;
                end else if (img_pend) begin
                    state_d   = IMG;
                    img_arm_d = 1'b0;
                end
            end
            KER: begin
                if (ker_load) begin
                    ker_cnt_d = ker_cnt_q - CNT_WIDTH'(1);
                    if (ker_cnt_q == CNT_WIDTH'(1)) begin
                        ker_done_d = 1'b1;
                        if (img_pend) begin
                            state_d   = IMG;
                            img_arm_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            IMG: begin
                if (img_load) begin
                    img_cnt_d = img_cnt_q - CNT_WIDTH'(1);
                    if (img_cnt_q == CNT_WIDTH'(1)) begin
                        img_done_d = 1'b1;
                        if (ker_pend) begin
                            state_d   = KER;
                            ker_arm_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output stages drain on their own ready regardless of the FSM state
    always_comb begin
        ker_bus_d = ker_bus_q;
        ker_val_d = ker_val_q;
        img_bus_d = img_bus_q;
        img_val_d = img_val_q;
        if (ker_load) begin
            ker_bus_d = up.bus;
            ker_val_d = 1'b1;
        end else if (ker.rdy) begin
            ker_val_d = 1'b0;
        end
        if (img_load) begin
            img_bus_d = up.bus;
            img_val_d = 1'b1;
        end else if (img.rdy) begin
            img_val_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ker_arm_q  <= 1'b0;
            img_arm_q  <= 1'b0;
            ker_cnt_q  <= '0;
            img_cnt_q  <= '0;
            ker_bus_q  <= '0;
            img_bus_q  <= '0;
            ker_val_q  <= 1'b0;
            img_val_q  <= 1'b0;
            ker_done_q <= 1'b0;
            img_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ker_arm_q  <= ker_arm_d;
            img_arm_q  <= img_arm_d;
            ker_cnt_q  <= ker_cnt_d;
            img_cnt_q  <= img_cnt_d;
            ker_bus_q  <= ker_bus_d;
            img_bus_q  <= img_bus_d;
            ker_val_q  <= ker_val_d;
            img_val_q  <= img_val_d;
            ker_done_q <= ker_done_d;
            img_done_q <= img_done_d;
        end
    end

    assign up.rdy   = up_rdy;
    assign ker.bus  = ker_bus_q;
    assign ker.val  = ker_val_q;
    assign img.bus  = img_bus_q;
    assign img.val  = img_val_q;
    assign ker_done = ker_done_q;
    assign img_done = img_done_q;
    assign busy     = state_q != IDLE || ker_arm_q || img_arm_q;

endmodule

// File: doc/str_route.md
# str_route

Upstream steering stage for the CNN coprocessor. A single host DMA stream (`up_*`) carries kernel and image data back-to-back. This block splits it onto the coprocessor's kernel input (`ker_*`) and image input (`img_*`) under control of word counts written over the shared configuration bus. Each output has one registered pipeline stage, so the coprocessor inputs see no combinational path from the DMA.

## Interface

Parameters:
- `CFG_DWIDTH`, 32: configuration data width.
- `CFG_AWIDTH`, 5: configuration address width.
- `STR_WIDTH`, 64: stream data width (up, ker and img are identical).
- `CNT_WIDTH`, 24: word-count register width; must be ≤ `CFG_DWIDTH`.
- `CFG_KER_ADDR`, 5'd24: config address that arms a kernel transfer.
- `CFG_IMG_ADDR`, 5'd25: config address that arms an image transfer.

Ports:
- `clk` input 1: the single clock; everything is rising-edge.
- `rst` input 1: asynchronous, active-low reset.
- `cfg_data` input `CFG_DWIDTH`: configuration write data.
- `cfg_addr` input `CFG_AWIDTH`: configuration write address.
- `cfg_valid` input 1: configuration write strobe (single cycle, no back-pressure).
- `up_bus` input `STR_WIDTH`: DMA stream data.
- `up_val` input 1: DMA stream valid.
- `up_rdy` output 1: DMA stream ready.
- `ker_bus` output `STR_WIDTH`: kernel stream data.
- `ker_val` output 1: kernel stream valid.
- `ker_rdy` input 1: kernel stream ready.
- `img_bus` output `STR_WIDTH`: image stream data.
- `img_val` output 1: image stream valid.
- `img_rdy` input 1: image stream ready.
- `ker_done` output 1: one-cycle pulse when the last kernel word has been accepted from `up`.
- `img_done` output 1: one-cycle pulse when the last image word has been accepted from `up`.
- `busy` output 1: high when the state is not IDLE or either arm flag is set.

## Operation

Configuration:
- When `cfg_valid` is high and `cfg_addr == CFG_KER_ADDR`, load `ker_cnt` from `cfg_data[CNT_WIDTH-1:0]` and set `ker_arm`, but only if the value is non-zero and neither `ker_arm` is set nor the state is KER. Otherwise the write is ignored.
- `CFG_IMG_ADDR` behaves the same way for `img_cnt`, `img_arm` and state IMG.
- Writes to any other address are ignored.

State machine (IDLE, KER, IMG):
- IDLE → KER when `ker_arm` is set; `ker_arm` clears on entry. This takes priority over the image transfer.
- IDLE → IMG when `img_arm` is set and `ker_arm` is not; `img_arm` clears on entry.
- KER: each `up` handshake (`up_val && up_rdy`) decrements `ker_cnt`.
  - On the handshake where `ker_cnt == 1`: `ker_done` pulses on the next cycle.
  - The state moves to IMG if `img_arm` is set (consuming `img_arm`), otherwise to IDLE.
- IMG: symmetric to KER. On completion it moves to KER if `ker_arm` is set, otherwise to IDLE.

Datapath:
- `up_rdy = (state==KER && (!ker_val || ker_rdy)) || (state==IMG && (!img_val || img_rdy))`. It is 0 in IDLE.
- An accepted word is loaded into the selected output register, and that channel's `val` is set.
- Each output `val` clears when its `rdy` is high and no new word is loaded into it.
- Output registers drain independently of the state. A kernel word still held in `ker_bus` does not block image words from flowing.
- The unselected output register is never written.

## Timing

- Reset (`rst` low, asynchronous): state = IDLE, `ker_arm` = `img_arm` = 0, `ker_cnt` = `img_cnt` = 0, all `val` = 0, `up_rdy` = 0, `ker_done` = `img_done` = 0, `busy` = 0. Bus registers are cleared to 0.
- Reset mid-transfer discards any partially transferred block and any held output words. No done pulse is issued.
- Arm to first ready: a config write in cycle N moves the state to KER/IMG at edge N+1. `up_rdy` can be high in cycle N+1.
- Latency is 1 cycle: a word accepted on `up` at edge N is presented on `ker_bus`/`img_bus` with `val` high from edge N onward.
- Throughput is 1 word per cycle while the downstream ready is held high.
- `ker_done`/`img_done` is asserted in the cycle after the last-word handshake. It is independent of when that word leaves the output register.
- Back-to-back blocks: the transition from KER to IMG (or IMG to KER) on the last word gives `up_rdy` for the next block in the very next cycle, with no bubble.
- A config write arriving in the same cycle as the last-word handshake of the other channel is registered. It is then picked up by the completion transition.
- `up_bus` must be held stable by the source while `up_val && !up_rdy`; the block does not sample it otherwise.

## Test plan

- **Kernel then image:** write KER=4 then IMG=3 while `ker_rdy = img_rdy = 1` and `up_val` is held high.
  - 4 words appear on ker, then 3 on img, with no gap.
  - `ker_done` pulses one cycle after word 4; `img_done` pulses one cycle after word 7.
  - `busy` falls the cycle after that.
- **Priority:** write IMG=2 and KER=2 in consecutive cycles while IDLE.
  - If IDLE has already moved to IMG, image goes first; otherwise kernel goes first.
  - Check the exact ordering against the cycle of each write.
- **Back-pressure:** KER=5, with `ker_rdy` toggling 1,0,0,1,…
  - All 5 words arrive in order with none duplicated or dropped.
  - `up_rdy` is low exactly when `ker_val && !ker_rdy`.
- **Illegal writes:** write KER=0, then KER=3, then KER=7 while the transfer is active.
  - Exactly 3 words are routed to ker.
  - The 0 and 7 writes have no effect, and `busy` drops after the 3-word transfer.
- **Independent drain:** KER=1 then IMG=2, with `ker_rdy` = 0 throughout.
  - The kernel word stays held in `ker_bus`.
  - Both image words pass to img.
  - `ker_val` stays high until `ker_rdy` rises.
- **Async reset mid-block:** assert `rst` low during word 2 of KER=6.
  - All outputs go to their reset values immediately, without waiting for a clock edge.
  - After release, a fresh KER=2 transfers exactly 2 words.
